// File: rtl/meas_frame_scheduler.sv
// Purpose: sequences one ring-oscillator measurement (clear, gated window, settle, capture)
//          and sends the results as one UART frame {HEADER, cc, dc, HEADER^cc^dc}.
// Latency: 1 + WINDOW_CYCLES + SETTLE_CYCLES cycles from start to capture, then 4 handshaked bytes.
// Backpressure: each byte is held on tx_data with tx_start high until tx_ready; waits forever.
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   run, single            level start (back-to-back frames) / one-shot start pulse when idle
//   cc_value, dc_value     8-bit measurement results, sampled once per frame
//   tx_ready               UART can accept a byte
//   meas_en, meas_rst      window enable / one-cycle clear to the measurement circuits
//   tx_data, tx_start      byte and byte request to the UART
//   busy, frame_count      not-idle flag / completed frame count (wraps at 256)
module meas_frame_scheduler #(
   parameter int unsigned WINDOW_CYCLES = 100000,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [7:0]  HEADER        = 8'hA5,
   parameter int unsigned CNT_W         = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       single,
   input  logic [7:0] cc_value,
   input  logic [7:0] dc_value,
   input  logic       tx_ready,
   output logic       meas_en,
   output logic       meas_rst,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       busy,
   output logic [7:0] frame_count
);

   typedef enum logic [2:0] {
      IDLE, CLEAR, MEASURE, SETTLE, SEND_HDR, SEND_CC, SEND_DC, SEND_CHK
   } state_t;

   localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       cc_q;
   logic [7:0]       dc_q;
   logic             sent;    // current byte accepted; next request waits for tx_ready
   logic             accept;
   logic [7:0]       chk;

   assign accept = tx_start & tx_ready;
   assign chk    = HEADER ^ cc_q ^ dc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         cc_q        <= '0;
         dc_q        <= '0;
         sent        <= 1'b0;
         meas_en     <= 1'b0;
         meas_rst    <= 1'b0;
         tx_data     <= '0;
         tx_start    <= 1'b0;
         busy        <= 1'b0;
         frame_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (run || single) begin
                  state    <= CLEAR;
                  meas_rst <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            CLEAR: begin
               meas_rst <= 1'b0;
               meas_en  <= 1'b1;
               cnt      <= WIN_LOAD;
               state    <= MEASURE;
            end
            MEASURE: begin
               if (cnt == '0) begin
                  meas_en <= 1'b0;
                  cnt     <= SET_LOAD;
                  state   <= SETTLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  // Capture edge: the only point where the inputs reach the frame.
                  cc_q     <= cc_value;
                  dc_q     <= dc_value;
                  tx_data  <= HEADER;
                  tx_start <= 1'b1;
                  state    <= SEND_HDR;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            SEND_HDR: begin
               if (accept) begin
                  tx_start <= 1'b0;
                  sent     <= 1'b1;
               end else if (sent && tx_ready) begin
                  sent     <= 1'b0;
                  tx_start <= 1'b1;
                  tx_data  <= cc_q;
                  state    <= SEND_CC;
               end
            end
            SEND_CC: begin
               if (accept) begin
                  tx_start <= 1'b0;
                  sent     <= 1'b1;
               end else if (sent && tx_ready) begin
                  sent     <= 1'b0;
                  tx_start <= 1'b1;
                  tx_data  <= dc_q;
                  state    <= SEND_DC;
               end
            end
            SEND_DC: begin
               if (accept) begin
                  tx_start <= 1'b0;
                  sent     <= 1'b1;
               end else if (sent && tx_ready) begin
                  sent     <= 1'b0;
                  tx_start <= 1'b1;
                  tx_data  <= chk;
                  state    <= SEND_CHK;
               end
            end
            SEND_CHK: begin
               if (accept) begin
                  tx_start    <= 1'b0;
                  frame_count <= frame_count + 1'b1;
                  if (run) begin
                     state    <= CLEAR;
                     meas_rst <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_meas_frame_scheduler.sv
module tb_meas_frame_scheduler;
   localparam int WIN = 8;
   localparam int SET = 2;
   localparam logic [7:0] HDR = 8'hA5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b1;
   logic       single = 1'b0;
   logic [7:0] cc_value = 8'h00;
   logic [7:0] dc_value = 8'h00;
   logic       tx_ready = 1'b1;
   logic       meas_en;
   logic       meas_rst;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       busy;
   logic [7:0] frame_count;

   meas_frame_scheduler #(
      .WINDOW_CYCLES(WIN),
      .SETTLE_CYCLES(SET),
      .HEADER(HDR),
      .CNT_W(24)
   ) dut (
      .clk(clk), .reset(reset), .run(run), .single(single),
      .cc_value(cc_value), .dc_value(dc_value), .tx_ready(tx_ready),
      .meas_en(meas_en), .meas_rst(meas_rst), .tx_data(tx_data), .tx_start(tx_start),
      .busy(busy), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Scoreboard and reference-model state (shared between stimulus and monitor).
   logic [7:0] exp_q[$];
   int         idx = 0;
   int         model_fc = 0;
   int         frames_started = 0;
   int         frames_done = 0;
   int         flushed = 0;
   logic [7:0] last_byte = 8'h00;
   bit         rand_vals = 1'b1;
   bit         rand_rdy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Background randomisation of results and UART readiness, after the stimulus slot.
   always begin
      @(posedge clk);
      #2;
      if (rand_vals) begin
         cc_value = 8'($urandom);
         dc_value = 8'($urandom);
      end
      if (rand_rdy) tx_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: derives the expected frame from the observed measurement timeline
   // and checks every byte the UART accepts against it.
   int         en_len = 0;
   int         settle_ctr = -1;
   logic       prev_en = 1'b0, prev_rst = 1'b0, prev_start = 1'b0, prev_acc = 1'b0;
   logic       prev_ready = 1'b0, prev_reset = 1'b0;
   logic [7:0] prev_data = 8'h00;
   bit         chk_next = 1'b0;
   logic       exp_cont = 1'b0;

   always @(negedge clk) begin
      logic       acc;
      logic [7:0] e;
      if (reset) begin
         if (!prev_reset) flushed = exp_q.size();
         exp_q.delete();
         idx = 0; model_fc = 0; frames_started = 0; frames_done = 0;
         en_len = 0; settle_ctr = -1; chk_next = 1'b0;
         prev_en = 1'b0; prev_rst = 1'b0; prev_start = 1'b0; prev_acc = 1'b0;
         prev_ready = 1'b0; prev_data = 8'h00;
      end else begin
         check("frame_count", frame_count, model_fc);
         if (chk_next) begin
            check("after_chk_busy", busy, exp_cont);
            check("after_chk_clear", meas_rst, exp_cont);
            chk_next = 1'b0;
         end
         if (meas_rst && !prev_rst) frames_started++;
         if (prev_rst) begin
            check("clear_one_cycle", meas_rst, 0);
            check("window_follows_clear", meas_en, 1);
         end
         if (meas_en) en_len++;
         if (!meas_en && prev_en) begin
            check("window_len", en_len, WIN);
            en_len = 0;
            settle_ctr = SET - 1;
         end
         // Values present at this negedge are the ones on the edge that ends settling.
         if (settle_ctr == 0) begin
            exp_q.push_back(HDR);
            exp_q.push_back(cc_value);
            exp_q.push_back(dc_value);
            exp_q.push_back(HDR ^ cc_value ^ dc_value);
            settle_ctr = -1;
         end else if (settle_ctr > 0) begin
            settle_ctr--;
         end
         if (prev_start && !prev_acc) begin
            check("tx_start_held", tx_start, 1);
            check("tx_data_held", tx_data, prev_data);
         end
         if (prev_acc) check("tx_gap", tx_start, 0);
         if (tx_start && !prev_start && idx != 0) check("req_waits_ready", prev_ready, 1);
         acc = tx_start && tx_ready;
         if (acc) begin
            last_byte = tx_data;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: actual %0h, required no byte (t=%0t)", tx_data, $time);
            end else begin
               e = exp_q.pop_front();
               check("tx_byte", tx_data, e);
            end
            idx++;
            if (idx == 4) begin
               idx = 0;
               model_fc = (model_fc + 1) % 256;
               frames_done++;
               chk_next = 1'b1;
               exp_cont = run;
            end
         end
         prev_en = meas_en; prev_rst = meas_rst; prev_start = tx_start;
         prev_acc = acc; prev_ready = tx_ready; prev_data = tx_data;
      end
      prev_reset = reset;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      run = 1'b0; single = 1'b0; reset = 1'b1;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic pulse_single();
      single = 1'b1;
      step();
      single = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy !== 1'b0 && n < bound) begin step(); n++; end
      check("idle_reached", busy, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: actual time limit reached, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      // T1: reset with run held high.
      repeat (3) step();
      check("rst_meas_en", meas_en, 0);
      check("rst_meas_rst", meas_rst, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_busy", busy, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_frame_count", frame_count, 0);
      reset = 1'b0;
      step();
      check("t1_clear_first_edge", meas_rst, 1);
      check("t1_busy", busy, 1);
      run = 1'b0;
      wait_idle(300);

      // T2: single frame with fixed results.
      do_reset();
      rand_vals = 1'b0; cc_value = 8'h3C; dc_value = 8'h81; tx_ready = 1'b1;
      pulse_single();
      wait_idle(300);
      check("t2_frame_count", frame_count, 1);
      check("t2_checksum_byte", last_byte, 8'h18);
      check("t2_frames_started", frames_started, 1);
      rand_vals = 1'b1;

      // T3: UART backpressure on the header.
      do_reset();
      tx_ready = 1'b0;
      pulse_single();
      n = 0;
      while (tx_start !== 1'b1 && n < 100) begin step(); n++; end
      check("t3_hdr_requested", tx_start, 1);
      repeat (50) step();
      check("t3_start_held", tx_start, 1);
      check("t3_data_held", tx_data, HDR);
      tx_ready = 1'b1;
      wait_idle(300);
      check("t3_frame_count", frame_count, 1);
      check("t3_queue_empty", exp_q.size(), 0);

      // T4: continuous run with random readiness, dropped during SEND_CC of frame 4.
      do_reset();
      rand_rdy = 1'b1;
      run = 1'b1;
      n = 0;
      while (!(frames_done == 3 && idx == 1 && tx_start === 1'b1) && n < 3000) begin step(); n++; end
      check("t4_reached_frame4_cc", frames_done, 3);
      run = 1'b0;
      wait_idle(3000);
      check("t4_frame_count", frame_count, 4);
      check("t4_frames_started", frames_started, 4);
      rand_rdy = 1'b0; tx_ready = 1'b1;

      // T5: single ignored while busy, then wrap of frame_count.
      do_reset();
      pulse_single();
      n = 0;
      while (meas_en !== 1'b1 && n < 50) begin step(); n++; end
      check("t5_in_measure", meas_en, 1);
      pulse_single();
      wait_idle(300);
      repeat (5) step();
      check("t5_no_extra_frame", frames_started, 1);
      check("t5_still_idle", busy, 0);
      for (int i = 1; i < 255; i++) begin
         pulse_single();
         wait_idle(300);
      end
      check("t5_count_255", frame_count, 255);
      pulse_single();
      wait_idle(300);
      check("t5_count_wrap", frame_count, 0);

      // T6: reset during SEND_DC abandons the frame.
      do_reset();
      tx_ready = 1'b1;
      pulse_single();
      n = 0;
      while (!(idx == 2 && tx_start === 1'b1) && n < 300) begin step(); n++; end
      check("t6_dc_requested", tx_data, exp_q.size() > 0 ? exp_q[0] : 8'hxx);
      tx_ready = 1'b0;
      reset = 1'b1;
      step();
      check("t6_tx_start_dropped", tx_start, 0);
      check("t6_frame_count", frame_count, 0);
      check("t6_busy", busy, 0);
      check("t6_abandoned_bytes", flushed, 2);
      reset = 1'b0;
      tx_ready = 1'b1;
      repeat (40) step();
      check("t6_no_restart", frames_started, 0);
      check("t6_no_request", tx_start, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
